br_lite_ni: RTL and testbench

PE-side network interface for one BrLite mesh node. It buffers flits from the processing element, delivers them to the router local input over the req/ack handshake, and accepts flits from the router local output into a receive buffer. The PE sees a plain valid/ready interface on each side. There is one instance per mesh index, and it connects to the per-node local-port signals of the BrLite NoC: `flit_i`/`req_i`/`ack_o` inbound to the NoC, and `flit_o`/`req_o`/`ack_i`/`busy_o` outbound from it.

---
 rtl/br_lite_ni_pkg.sv | 9 +
 rtl/br_lite_ni_if.sv | 40 ++++
 rtl/br_lite_ni.sv | 181 ++++++++++++++++++
 tb/tb_br_lite_ni.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/br_lite_ni_pkg.sv
// Shared payload type for the BrLite network interface.
package br_lite_pkg;

  typedef struct packed {
    logic [15:0] hdr;
    logic [15:0] payload;
  } br_data_t;

endpackage

// File: rtl/br_lite_ni_if.sv
// PE and NoC-local-port signal bundle for br_lite_ni.
// slave is the NI side, master is the PE/router environment side.
interface br_lite_ni_if #(
  parameter int unsigned RX_DEPTH = 4
);
  import br_lite_pkg::*;

  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  br_data_t             tx_flit_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  br_data_t             rx_flit_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  br_data_t             noc_flit_o;
  logic                 noc_req_o;
  logic                 noc_ack_i;
  br_data_t             noc_flit_i;
  logic                 noc_req_i;
  logic                 noc_ack_o;
  logic                 noc_busy_i;
  logic                 tx_empty_o;
  logic [RX_CW-1:0]     rx_count_o;
  logic [31:0]          tx_cnt_o;
  logic [31:0]          rx_cnt_o;

  modport slave (
    input  tx_flit_i, tx_valid_i, rx_ready_i, noc_ack_i, noc_flit_i, noc_req_i, noc_busy_i,
    output tx_ready_o, rx_flit_o, rx_valid_o, noc_flit_o, noc_req_o, noc_ack_o,
           tx_empty_o, rx_count_o, tx_cnt_o, rx_cnt_o
  );

  modport master (
    output tx_flit_i, tx_valid_i, rx_ready_i, noc_ack_i, noc_flit_i, noc_req_i, noc_busy_i,
    input  tx_ready_o, rx_flit_o, rx_valid_o, noc_flit_o, noc_req_o, noc_ack_o,
           tx_empty_o, rx_count_o, tx_cnt_o, rx_cnt_o
  );

endinterface

// File: rtl/br_lite_ni.sv
// BrLite PE-side network interface: TX/RX FIFOs bridging valid/ready to 4-phase req/ack.
// Optional flit statistics counters are built when BR_NI_STATS_EN is defined.
module br_lite_ni #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  br_lite_ni_if.slave   bus
);
  import br_lite_pkg::*;

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  localparam logic [1:0] TX_IDLE     = 2'd0;
  localparam logic [1:0] TX_REQ      = 2'd1;
  localparam logic [1:0] TX_WAIT_LOW = 2'd2;
  localparam logic [0:0] RX_IDLE     = 1'b0;
  localparam logic [0:0] RX_ACK      = 1'b1;

  br_data_t           tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]   tx_wr, tx_rd;
  logic [TX_CW-1:0]   tx_count;
  logic               tx_full, tx_push, tx_pop;

  br_data_t           rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]   rx_wr, rx_rd;
  logic [RX_CW-1:0]   rx_count;
  logic               rx_full, rx_valid, rx_push, rx_pop;

  logic [1:0]         tx_state, tx_state_nxt;
  logic               noc_req_q, noc_req_nxt;
  br_data_t           noc_flit_q, noc_flit_nxt;
  logic [0:0]         rx_state, rx_state_nxt;
  logic               noc_ack_q, noc_ack_nxt;

  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_push  = bus.tx_valid_i && !tx_full;
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid && bus.rx_ready_i;

  // FIFO storage is not reset; the occupancy counters define validity.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_flit_i;
    if (rx_push) rx_mem[rx_wr] <= bus.noc_flit_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // FSM state and registered NoC-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state   <= TX_IDLE;
      noc_req_q  <= 1'b0;
      noc_flit_q <= '0;
      rx_state   <= RX_IDLE;
      noc_ack_q  <= 1'b0;
    end else begin
      tx_state   <= tx_state_nxt;
      noc_req_q  <= noc_req_nxt;
      noc_flit_q <= noc_flit_nxt;
      rx_state   <= rx_state_nxt;
      noc_ack_q  <= noc_ack_nxt;
    end
  end

  // TX: busy only gates the start of a transfer, never an in-flight one.
  always_comb begin
    tx_state_nxt = tx_state;
    noc_req_nxt  = noc_req_q;
    noc_flit_nxt = noc_flit_q;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if ((tx_count != '0) && !bus.noc_busy_i) begin
          noc_flit_nxt = tx_mem[tx_rd];
          noc_req_nxt  = 1'b1;
          tx_state_nxt = TX_REQ;
        end
      end
      TX_REQ: begin
        if (bus.noc_ack_i) begin
          noc_req_nxt  = 1'b0;
          tx_pop       = 1'b1;
          tx_state_nxt = TX_WAIT_LOW;
        end
      end
      TX_WAIT_LOW: begin
        if (!bus.noc_ack_i) tx_state_nxt = TX_IDLE;
      end
      default: begin
        noc_req_nxt  = 1'b0;
        tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  // RX: withholding ack while full stalls the router.
  always_comb begin
    rx_state_nxt = rx_state;
    noc_ack_nxt  = noc_ack_q;
    rx_push      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (bus.noc_req_i && !rx_full) begin
          rx_push      = 1'b1;
          noc_ack_nxt  = 1'b1;
          rx_state_nxt = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!bus.noc_req_i) begin
          noc_ack_nxt  = 1'b0;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: begin
        noc_ack_nxt  = 1'b0;
        rx_state_nxt = RX_IDLE;
      end
    endcase
  end

`ifdef BR_NI_STATS_EN
  logic [31:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_pop)  tx_cnt_q <= tx_cnt_q + 32'd1;
      if (rx_push) rx_cnt_q <= rx_cnt_q + 32'd1;
    end
  end

  assign bus.tx_cnt_o = tx_cnt_q;
  assign bus.rx_cnt_o = rx_cnt_q;
`else
  assign bus.tx_cnt_o = '0;
  assign bus.rx_cnt_o = '0;
`endif

  assign bus.tx_ready_o = !tx_full;
  assign bus.rx_valid_o = rx_valid;
  assign bus.rx_flit_o  = rx_valid ? rx_mem[rx_rd] : '0;
  assign bus.noc_flit_o = noc_flit_q;
  assign bus.noc_req_o  = noc_req_q;
  assign bus.noc_ack_o  = noc_ack_q;
  assign bus.tx_empty_o = (tx_count == '0) && (tx_state == TX_IDLE);
  assign bus.rx_count_o = rx_count;

endmodule

// File: tb/tb_br_lite_ni.sv
// Directed self-checking bench for br_lite_ni: vector table plus handshake corner sequences.
module tb_br_lite_ni;
  import br_lite_pkg::*;

`ifdef BR_NI_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  br_lite_ni_if #(.RX_DEPTH(4)) bus ();

  br_lite_ni #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst, tx_v;
    logic [7:0] tx_d;
    logic       ack, busy, req_i;
    logic [7:0] rx_d;
    logic       rx_rdy;
    logic       e_req;
    logic [7:0] e_flit;
    logic       e_rdy, e_empty, e_acko, e_rxv;
    logic [2:0] e_cnt;
    logic [7:0] e_rxf;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // NoC-side responder: ack one cycle after req, drop ack one cycle after req falls.
  task automatic tx_accept(input logic [7:0] exp, input string name);
    int n;
    n = 0;
    while (!bus.noc_req_o && n < 20) begin step(); n++; end
    check({name, "_req"}, 32'(bus.noc_req_o), 32'd1);
    check({name, "_flit"}, 32'(bus.noc_flit_o), 32'(exp));
    step();
    check({name, "_hold"}, 32'(bus.noc_flit_o), 32'(exp));
    bus.noc_ack_i = 1'b1;
    n = 0;
    while (bus.noc_req_o && n < 20) begin step(); n++; end
    check({name, "_reqlow"}, 32'(bus.noc_req_o), 32'd0);
    step();
    bus.noc_ack_i = 1'b0;
    step();
  endtask

  // NoC-side driver: one complete 4-phase transfer into the NI.
  task automatic rx_send(input logic [7:0] v, input string name);
    int n;
    bus.noc_req_i  = 1'b1;
    bus.noc_flit_i = br_data_t'(32'(v));
    n = 0;
    while (!bus.noc_ack_o && n < 10) begin step(); n++; end
    check({name, "_ack"}, 32'(bus.noc_ack_o), 32'd1);
    bus.noc_req_i = 1'b0;
    n = 0;
    while (bus.noc_ack_o && n < 10) begin step(); n++; end
    check({name, "_acklow"}, 32'(bus.noc_ack_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_flit_i  = '0;
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    bus.noc_ack_i  = 1'b0;
    bus.noc_flit_i = '0;
    bus.noc_req_i  = 1'b0;
    bus.noc_busy_i = 1'b0;

    //          rst  txv  txd    ack  busy reqi rxd    rdy | req  flit   rdy  emp  acko rxv  cnt   rxf
    vecs[0]  = '{1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,3'd0, 8'h00};
    vecs[1]  = '{1'b0,1'b1,8'hA5, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,3'd0, 8'h00};
    vecs[2]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b1,8'hA5, 1'b1,1'b0,1'b0,1'b0,3'd0, 8'h00};
    vecs[3]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b1,8'hA5, 1'b1,1'b0,1'b0,1'b0,3'd0, 8'h00};
    vecs[4]  = '{1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'hA5, 1'b1,1'b0,1'b0,1'b0,3'd0, 8'h00};
    vecs[5]  = '{1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'hA5, 1'b1,1'b0,1'b0,1'b0,3'd0, 8'h00};
    vecs[6]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'hA5, 1'b1,1'b1,1'b0,1'b0,3'd0, 8'h00};
    vecs[7]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,8'h3C, 1'b0, 1'b0,8'hA5, 1'b1,1'b1,1'b1,1'b1,3'd1, 8'h3C};
    vecs[8]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,8'h3C, 1'b0, 1'b0,8'hA5, 1'b1,1'b1,1'b1,1'b1,3'd1, 8'h3C};
    vecs[9]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'hA5, 1'b1,1'b1,1'b0,1'b1,3'd1, 8'h3C};
    vecs[10] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,8'h5A, 1'b1, 1'b0,8'hA5, 1'b1,1'b1,1'b1,1'b1,3'd1, 8'h5A};
    vecs[11] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,8'h5A, 1'b1, 1'b0,8'hA5, 1'b1,1'b1,1'b1,1'b0,3'd0, 8'h00};
    vecs[12] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b0,8'hA5, 1'b1,1'b1,1'b0,1'b0,3'd0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst            = vecs[i].rst;
      bus.tx_valid_i = vecs[i].tx_v;
      bus.tx_flit_i  = br_data_t'(32'(vecs[i].tx_d));
      bus.noc_ack_i  = vecs[i].ack;
      bus.noc_busy_i = vecs[i].busy;
      bus.noc_req_i  = vecs[i].req_i;
      bus.noc_flit_i = br_data_t'(32'(vecs[i].rx_d));
      bus.rx_ready_i = vecs[i].rx_rdy;
      step();
      check($sformatf("v%0d_noc_req", i),  32'(bus.noc_req_o),  32'(vecs[i].e_req));
      check($sformatf("v%0d_noc_flit", i), 32'(bus.noc_flit_o), 32'(vecs[i].e_flit));
      check($sformatf("v%0d_tx_ready", i), 32'(bus.tx_ready_o), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_tx_empty", i), 32'(bus.tx_empty_o), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_noc_ack", i),  32'(bus.noc_ack_o),  32'(vecs[i].e_acko));
      check($sformatf("v%0d_rx_valid", i), 32'(bus.rx_valid_o), 32'(vecs[i].e_rxv));
      check($sformatf("v%0d_rx_count", i), 32'(bus.rx_count_o), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_rx_flit", i),  32'(bus.rx_flit_o),  32'(vecs[i].e_rxf));
    end
    check("vec_tx_cnt", bus.tx_cnt_o, STATS ? 32'd1 : 32'd0);
    check("vec_rx_cnt", bus.rx_cnt_o, STATS ? 32'd2 : 32'd0);

    // Busy gating: flits queue but no request leaves while busy.
    do_reset();
    bus.noc_busy_i = 1'b1;
    bus.tx_valid_i = 1'b1;
    bus.tx_flit_i  = br_data_t'(32'h11);
    step();
    bus.tx_flit_i  = br_data_t'(32'h22);
    step();
    bus.tx_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("busy_req%0d", k), 32'(bus.noc_req_o), 32'd0);
      check($sformatf("busy_rdy%0d", k), 32'(bus.tx_ready_o), 32'd1);
    end
    check("busy_not_empty", 32'(bus.tx_empty_o), 32'd0);
    bus.noc_busy_i = 1'b0;
    tx_accept(8'h11, "busy_f1");
    tx_accept(8'h22, "busy_f2");
    check("busy_drained", 32'(bus.tx_empty_o), 32'd1);

    // TX full: ack withheld, four pushes fill the FIFO, a fifth is refused.
    do_reset();
    bus.tx_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.tx_flit_i = br_data_t'(32'(k));
      step();
    end
    check("full_rdy", 32'(bus.tx_ready_o), 32'd0);
    bus.tx_flit_i = br_data_t'(32'h5);
    step();
    bus.tx_valid_i = 1'b0;
    check("full_rdy_hold", 32'(bus.tx_ready_o), 32'd0);
    tx_accept(8'h01, "full_f1");
    check("full_rdy_free", 32'(bus.tx_ready_o), 32'd1);
    tx_accept(8'h02, "full_f2");
    tx_accept(8'h03, "full_f3");
    tx_accept(8'h04, "full_f4");
    step();
    check("full_no_fifth", 32'(bus.tx_empty_o), 32'd1);
    check("full_req_idle", 32'(bus.noc_req_o), 32'd0);

    // RX backpressure: fifth request stalls until the PE frees a slot.
    do_reset();
    for (int k = 1; k <= 4; k++) rx_send(8'(k), $sformatf("rx_f%0d", k));
    check("rx_count4", 32'(bus.rx_count_o), 32'd4);
    bus.noc_req_i  = 1'b1;
    bus.noc_flit_i = br_data_t'(32'h5);
    repeat (3) step();
    check("rx_f5_stall", 32'(bus.noc_ack_o), 32'd0);
    check("rx_count_full", 32'(bus.rx_count_o), 32'd4);
    check("rx_head1", 32'(bus.rx_flit_o), 32'd1);
    bus.rx_ready_i = 1'b1;
    step();
    bus.rx_ready_i = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.noc_ack_o && n < 10) begin step(); n++; end
    end
    check("rx_f5_ack", 32'(bus.noc_ack_o), 32'd1);
    bus.noc_req_i = 1'b0;
    step();
    check("rx_f5_acklow", 32'(bus.noc_ack_o), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("rx_read%0d_valid", k), 32'(bus.rx_valid_o), 32'd1);
      check($sformatf("rx_read%0d", k), 32'(bus.rx_flit_o), 32'(k));
      bus.rx_ready_i = 1'b1;
      step();
      bus.rx_ready_i = 1'b0;
    end
    check("rx_drained", 32'(bus.rx_valid_o), 32'd0);

    // Reset with TX in REQ and RX in ACK.
    do_reset();
    bus.tx_valid_i = 1'b1;
    bus.tx_flit_i  = br_data_t'(32'h77);
    step();
    bus.tx_valid_i = 1'b0;
    bus.noc_req_i  = 1'b1;
    bus.noc_flit_i = br_data_t'(32'h44);
    step();
    check("mid_req", 32'(bus.noc_req_o), 32'd1);
    check("mid_ack", 32'(bus.noc_ack_o), 32'd1);
    check("mid_rx_cnt", bus.rx_cnt_o, STATS ? 32'd1 : 32'd0);
    rst = 1'b1;
    step();
    check("rst_req", 32'(bus.noc_req_o), 32'd0);
    check("rst_ack", 32'(bus.noc_ack_o), 32'd0);
    check("rst_flit", 32'(bus.noc_flit_o), 32'd0);
    check("rst_tx_empty", 32'(bus.tx_empty_o), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    check("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_rx_count", 32'(bus.rx_count_o), 32'd0);
    check("rst_tx_cnt", bus.tx_cnt_o, 32'd0);
    check("rst_rx_cnt", bus.rx_cnt_o, 32'd0);
    rst = 1'b0;
    bus.noc_req_i = 1'b0;
    step();
    check("post_rst_req", 32'(bus.noc_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
